// File: rtl/sc_mem_arbiter.sv
// rtl/sc_mem_arbiter.sv - single-port main-memory access controller and CPU/loader arbiter
//
// Purpose: shares one single-port memory between the microprogrammed control
// unit (MIR RD/WR strobes) and the external program-loader port. Each access
// holds the memory strobes for WAIT_STATES+1 cycles, then a one-cycle Done.
// The control unit is stalled until its own access reaches Done.
//
// Ports:
//   SC_MemArbiter_CLOCK_50          clock, rising edge
//   SC_MemArbiter_RESET_InLow       asynchronous active-low reset
//   SC_MemArbiter_CPU_*             control-unit side: RD/WR strobes, address,
//                                   write data, registered read data, Stall, Done
//   SC_MemArbiter_LD_*              loader side: level request, op, address,
//                                   write data, registered read data, Grant, Done
//   SC_MemArbiter_MEM_*             memory side: latched address/write data,
//                                   read data in, read/write strobes
module sc_mem_arbiter #(
  parameter int DATAWIDTH_ADDR = 32,
  parameter int DATAWIDTH_DATA = 32,
  parameter int WAIT_STATES    = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      SC_MemArbiter_CLOCK_50,
  input  logic                      SC_MemArbiter_RESET_InLow,
  input  logic                      SC_MemArbiter_CPU_Read_InHigh,
  input  logic                      SC_MemArbiter_CPU_Write_InHigh,
  input  logic [DATAWIDTH_ADDR-1:0] SC_MemArbiter_CPU_Addr_InBUS,
  input  logic [DATAWIDTH_DATA-1:0] SC_MemArbiter_CPU_Data_InBUS,
  output logic [DATAWIDTH_DATA-1:0] SC_MemArbiter_CPU_Data_OutBUS,
  output logic                      SC_MemArbiter_CPU_Stall_OutHigh,
  output logic                      SC_MemArbiter_CPU_Done_OutHigh,
  input  logic                      SC_MemArbiter_LD_Req_InHigh,
  input  logic                      SC_MemArbiter_LD_Write_InHigh,
  input  logic [DATAWIDTH_ADDR-1:0] SC_MemArbiter_LD_Addr_InBUS,
  input  logic [DATAWIDTH_DATA-1:0] SC_MemArbiter_LD_Data_InBUS,
  output logic [DATAWIDTH_DATA-1:0] SC_MemArbiter_LD_Data_OutBUS,
  output logic                      SC_MemArbiter_LD_Grant_OutHigh,
  output logic                      SC_MemArbiter_LD_Done_OutHigh,
  output logic [DATAWIDTH_ADDR-1:0] SC_MemArbiter_MEM_Addr_OutBUS,
  output logic [DATAWIDTH_DATA-1:0] SC_MemArbiter_MEM_Data_OutBUS,
  input  logic [DATAWIDTH_DATA-1:0] SC_MemArbiter_MEM_Data_InBUS,
  output logic                      SC_MemArbiter_MEM_Read_OutHigh,
  output logic                      SC_MemArbiter_MEM_Write_OutHigh
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } stateT;

  localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_STATES);
  localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);

  stateT      state;
  logic       ownerLd;    // 1 = loader owns the current access
  logic       opWrite;    // latched operation of the current access
  logic [3:0] waitCnt;
  logic [3:0] starveCnt;  // CPU grants issued while the loader was waiting

  logic cpuReq;
  logic grantLd;

  assign cpuReq = SC_MemArbiter_CPU_Read_InHigh | SC_MemArbiter_CPU_Write_InHigh;

  // Loader wins when it is alone, or when the CPU has used up its quota of
  // consecutive grants against a pending loader.
  assign grantLd = SC_MemArbiter_LD_Req_InHigh &
                   (~cpuReq | (starveCnt == STARVE_MAX));

  // Combinational so the MIR advances exactly in the CPU's Done cycle and
  // stays frozen through reset while the strobes are held.
  assign SC_MemArbiter_CPU_Stall_OutHigh = cpuReq & ~((state == DONE) & ~ownerLd);

  always_ff @(posedge SC_MemArbiter_CLOCK_50 or negedge SC_MemArbiter_RESET_InLow) begin
    if (!SC_MemArbiter_RESET_InLow) begin
      state                           <= IDLE;
      ownerLd                         <= 1'b0;
      opWrite                         <= 1'b0;
      waitCnt                         <= 4'd0;
      starveCnt                       <= 4'd0;
      SC_MemArbiter_CPU_Data_OutBUS   <= '0;
      SC_MemArbiter_CPU_Done_OutHigh  <= 1'b0;
      SC_MemArbiter_LD_Data_OutBUS    <= '0;
      SC_MemArbiter_LD_Grant_OutHigh  <= 1'b0;
      SC_MemArbiter_LD_Done_OutHigh   <= 1'b0;
      SC_MemArbiter_MEM_Addr_OutBUS   <= '0;
      SC_MemArbiter_MEM_Data_OutBUS   <= '0;
      SC_MemArbiter_MEM_Read_OutHigh  <= 1'b0;
      SC_MemArbiter_MEM_Write_OutHigh <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!SC_MemArbiter_LD_Req_InHigh) begin
            starveCnt <= 4'd0;
          end
          if (grantLd) begin
            ownerLd                         <= 1'b1;
            opWrite                         <= SC_MemArbiter_LD_Write_InHigh;
            SC_MemArbiter_MEM_Addr_OutBUS   <= SC_MemArbiter_LD_Addr_InBUS;
            SC_MemArbiter_MEM_Data_OutBUS   <= SC_MemArbiter_LD_Data_InBUS;
            SC_MemArbiter_MEM_Write_OutHigh <= SC_MemArbiter_LD_Write_InHigh;
            SC_MemArbiter_MEM_Read_OutHigh  <= ~SC_MemArbiter_LD_Write_InHigh;
            SC_MemArbiter_LD_Grant_OutHigh  <= 1'b1;
            waitCnt                         <= WAIT_LOAD;
            starveCnt                       <= 4'd0;
            state                           <= ACCESS;
          end else if (cpuReq) begin
            // RD and WR together resolve to a write.
            ownerLd                         <= 1'b0;
            opWrite                         <= SC_MemArbiter_CPU_Write_InHigh;
            SC_MemArbiter_MEM_Addr_OutBUS   <= SC_MemArbiter_CPU_Addr_InBUS;
            SC_MemArbiter_MEM_Data_OutBUS   <= SC_MemArbiter_CPU_Data_InBUS;
            SC_MemArbiter_MEM_Write_OutHigh <= SC_MemArbiter_CPU_Write_InHigh;
            SC_MemArbiter_MEM_Read_OutHigh  <= ~SC_MemArbiter_CPU_Write_InHigh;
            waitCnt                         <= WAIT_LOAD;
            if (SC_MemArbiter_LD_Req_InHigh && (starveCnt != STARVE_MAX)) begin
              starveCnt <= starveCnt + 4'd1;
            end
            state                           <= ACCESS;
          end
        end

        ACCESS: begin
          if (waitCnt == 4'd0) begin
            SC_MemArbiter_MEM_Read_OutHigh  <= 1'b0;
            SC_MemArbiter_MEM_Write_OutHigh <= 1'b0;
            if (!opWrite) begin
              if (ownerLd) begin
                SC_MemArbiter_LD_Data_OutBUS  <= SC_MemArbiter_MEM_Data_InBUS;
              end else begin
                SC_MemArbiter_CPU_Data_OutBUS <= SC_MemArbiter_MEM_Data_InBUS;
              end
            end
            if (ownerLd) begin
              SC_MemArbiter_LD_Done_OutHigh  <= 1'b1;
            end else begin
              SC_MemArbiter_CPU_Done_OutHigh <= 1'b1;
            end
            state <= DONE;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end

        DONE: begin
          // Requests are not sampled here; the requester changes its inputs
          // during this cycle.
          SC_MemArbiter_CPU_Done_OutHigh <= 1'b0;
          SC_MemArbiter_LD_Done_OutHigh  <= 1'b0;
          SC_MemArbiter_LD_Grant_OutHigh <= 1'b0;
          state                          <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_mem_arbiter.sv
// tb/tb_sc_mem_arbiter.sv - directed self-checking bench for sc_mem_arbiter
module tb_sc_mem_arbiter;

  logic clk;
  logic rstN;

  // DUT A: WAIT_STATES=2, STARVE_LIMIT=4
  logic        cpuRd, cpuWr;
  logic [31:0] cpuAddr, cpuWdata, cpuRdata;
  logic        cpuStall, cpuDone;
  logic        ldReq, ldWr;
  logic [31:0] ldAddr, ldWdata, ldRdata;
  logic        ldGrant, ldDone;
  logic [31:0] memAddr, memWdata, memRdata;
  logic        memRd, memWr;

  // DUT B: WAIT_STATES=0
  logic        cpuRdB, cpuWrB;
  logic [31:0] cpuAddrB, cpuWdataB, cpuRdataB;
  logic        cpuStallB, cpuDoneB;
  logic        ldReqB, ldWrB;
  logic [31:0] ldAddrB, ldWdataB, ldRdataB;
  logic        ldGrantB, ldDoneB;
  logic [31:0] memAddrB, memWdataB, memRdataB;
  logic        memRdB, memWrB;

  int nCmp;
  int nErr;

  logic [31:0] memArr [0:1023];

  sc_mem_arbiter #(.DATAWIDTH_ADDR(32), .DATAWIDTH_DATA(32), .WAIT_STATES(2), .STARVE_LIMIT(4)) dutA (
    .SC_MemArbiter_CLOCK_50         (clk),
    .SC_MemArbiter_RESET_InLow      (rstN),
    .SC_MemArbiter_CPU_Read_InHigh  (cpuRd),
    .SC_MemArbiter_CPU_Write_InHigh (cpuWr),
    .SC_MemArbiter_CPU_Addr_InBUS   (cpuAddr),
    .SC_MemArbiter_CPU_Data_InBUS   (cpuWdata),
    .SC_MemArbiter_CPU_Data_OutBUS  (cpuRdata),
    .SC_MemArbiter_CPU_Stall_OutHigh(cpuStall),
    .SC_MemArbiter_CPU_Done_OutHigh (cpuDone),
    .SC_MemArbiter_LD_Req_InHigh    (ldReq),
    .SC_MemArbiter_LD_Write_InHigh  (ldWr),
    .SC_MemArbiter_LD_Addr_InBUS    (ldAddr),
    .SC_MemArbiter_LD_Data_InBUS    (ldWdata),
    .SC_MemArbiter_LD_Data_OutBUS   (ldRdata),
    .SC_MemArbiter_LD_Grant_OutHigh (ldGrant),
    .SC_MemArbiter_LD_Done_OutHigh  (ldDone),
    .SC_MemArbiter_MEM_Addr_OutBUS  (memAddr),
    .SC_MemArbiter_MEM_Data_OutBUS  (memWdata),
    .SC_MemArbiter_MEM_Data_InBUS   (memRdata),
    .SC_MemArbiter_MEM_Read_OutHigh (memRd),
    .SC_MemArbiter_MEM_Write_OutHigh(memWr)
  );

  sc_mem_arbiter #(.DATAWIDTH_ADDR(32), .DATAWIDTH_DATA(32), .WAIT_STATES(0), .STARVE_LIMIT(4)) dutB (
    .SC_MemArbiter_CLOCK_50         (clk),
    .SC_MemArbiter_RESET_InLow      (rstN),
    .SC_MemArbiter_CPU_Read_InHigh  (cpuRdB),
    .SC_MemArbiter_CPU_Write_InHigh (cpuWrB),
    .SC_MemArbiter_CPU_Addr_InBUS   (cpuAddrB),
    .SC_MemArbiter_CPU_Data_InBUS   (cpuWdataB),
    .SC_MemArbiter_CPU_Data_OutBUS  (cpuRdataB),
    .SC_MemArbiter_CPU_Stall_OutHigh(cpuStallB),
    .SC_MemArbiter_CPU_Done_OutHigh (cpuDoneB),
    .SC_MemArbiter_LD_Req_InHigh    (ldReqB),
    .SC_MemArbiter_LD_Write_InHigh  (ldWrB),
    .SC_MemArbiter_LD_Addr_InBUS    (ldAddrB),
    .SC_MemArbiter_LD_Data_InBUS    (ldWdataB),
    .SC_MemArbiter_LD_Data_OutBUS   (ldRdataB),
    .SC_MemArbiter_LD_Grant_OutHigh (ldGrantB),
    .SC_MemArbiter_LD_Done_OutHigh  (ldDoneB),
    .SC_MemArbiter_MEM_Addr_OutBUS  (memAddrB),
    .SC_MemArbiter_MEM_Data_OutBUS  (memWdataB),
    .SC_MemArbiter_MEM_Data_InBUS   (memRdataB),
    .SC_MemArbiter_MEM_Read_OutHigh (memRdB),
    .SC_MemArbiter_MEM_Write_OutHigh(memWrB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model for DUT A: 0x100 is a fixed ROM word, everything else is RAM.
  always_comb memRdata = (memAddr == 32'h100) ? 32'hDEADBEEF : memArr[memAddr[9:0]];
  always @(posedge clk) if (memWr) memArr[memAddr[9:0]] <= memWdata;

  // Memory model for DUT B: read data is a fixed function of the address.
  assign memRdataB = memAddrB ^ 32'h5A5A0000;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // CPU access on DUT A; called #1 after an edge with the DUT idle. The
  // request is dropped one edge after Done is seen.
  task automatic runCpu(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int rdCyc, output int wrCyc,
                        output int stallCyc, output int doneCyc, output int doneCnt);
    logic sawDone;
    rdCyc = 0; wrCyc = 0; stallCyc = 0; doneCyc = -1; doneCnt = 0; sawDone = 1'b0;
    cpuAddr = addr; cpuWdata = wdata; cpuRd = rd; cpuWr = wr;
    for (int c = 0; c < 12; c++) begin
      if (memRd) rdCyc++;
      if (memWr) wrCyc++;
      if (cpuStall) stallCyc++;
      if (cpuDone) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = c;
        sawDone = 1'b1;
      end
      @(posedge clk); #1;
      if (sawDone) begin cpuRd = 1'b0; cpuWr = 1'b0; end
    end
    cpuRd = 1'b0; cpuWr = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    nCmp++; if (memRd !== 1'b0 || memWr !== 1'b0) begin nErr++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 0/0", memRd, memWr); end
    nCmp++; if (cpuDone !== 1'b0 || ldDone !== 1'b0 || ldGrant !== 1'b0) begin nErr++; $display("FAIL reset_handshake: got cdone=%b ldone=%b grant=%b expected 0", cpuDone, ldDone, ldGrant); end
    nCmp++; if (cpuRdata !== 32'h0 || ldRdata !== 32'h0 || memAddr !== 32'h0 || memWdata !== 32'h0) begin nErr++; $display("FAIL reset_data: got %h %h %h %h expected 0", cpuRdata, ldRdata, memAddr, memWdata); end
    nCmp++; if (cpuStall !== 1'b0) begin nErr++; $display("FAIL reset_stall_idle: got %b expected 0", cpuStall); end
    cpuRd = 1'b1; #1;
    nCmp++; if (cpuStall !== 1'b1) begin nErr++; $display("FAIL reset_stall_follows: got %b expected 1", cpuStall); end
    cpuRd = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_read;
    int rdC, wrC, stC, dC, dN;
    runCpu(1'b1, 1'b0, 32'h100, 32'h0, rdC, wrC, stC, dC, dN);
    nCmp++; if (rdC !== 3) begin nErr++; $display("FAIL cpu_read_memrd_cycles: got %0d expected 3", rdC); end
    nCmp++; if (wrC !== 0) begin nErr++; $display("FAIL cpu_read_memwr_cycles: got %0d expected 0", wrC); end
    nCmp++; if (stC !== 4) begin nErr++; $display("FAIL cpu_read_stall_cycles: got %0d expected 4", stC); end
    nCmp++; if (dC !== 4 || dN !== 1) begin nErr++; $display("FAIL cpu_read_done: got cycle %0d count %0d expected cycle 4 count 1", dC, dN); end
    nCmp++; if (cpuRdata !== 32'hDEADBEEF) begin nErr++; $display("FAIL cpu_read_data: got %h expected deadbeef", cpuRdata); end
  endtask

  task automatic test_loader_write;
    int grC, wrC, rdC, dC, dN, addrBad;
    int rdC2, wrC2, stC2, dC2, dN2;
    grC = 0; wrC = 0; rdC = 0; dC = -1; dN = 0; addrBad = 0;
    ldAddr = 32'h40; ldWdata = 32'h12345678; ldWr = 1'b1; ldReq = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (ldGrant) grC++;
      if (memRd) rdC++;
      if (memWr) begin
        wrC++;
        if (memAddr !== 32'h40 || memWdata !== 32'h12345678) addrBad++;
      end
      if (ldDone) begin
        dN++;
        if (dC < 0) dC = c;
        ldReq = 1'b0;
      end
      @(posedge clk); #1;
    end
    ldReq = 1'b0; ldWr = 1'b0;
    nCmp++; if (wrC !== 3 || rdC !== 0) begin nErr++; $display("FAIL ld_write_strobes: got wr=%0d rd=%0d expected 3/0", wrC, rdC); end
    nCmp++; if (addrBad !== 0) begin nErr++; $display("FAIL ld_write_addr: got %0d bad cycles expected 0", addrBad); end
    nCmp++; if (grC !== 4) begin nErr++; $display("FAIL ld_write_grant_cycles: got %0d expected 4", grC); end
    nCmp++; if (dN !== 1 || dC !== 4) begin nErr++; $display("FAIL ld_write_done: got count %0d cycle %0d expected 1 at 4", dN, dC); end
    runCpu(1'b1, 1'b0, 32'h40, 32'h0, rdC2, wrC2, stC2, dC2, dN2);
    nCmp++; if (cpuRdata !== 32'h12345678 || dC2 !== 4) begin nErr++; $display("FAIL ld_write_readback: got %h done %0d expected 12345678 done 4", cpuRdata, dC2); end
  endtask

  task automatic test_rd_wr_both;
    int rdC, wrC, stC, dC, dN;
    runCpu(1'b1, 1'b1, 32'h80, 32'hCAFEF00D, rdC, wrC, stC, dC, dN);
    nCmp++; if (wrC !== 3 || rdC !== 0) begin nErr++; $display("FAIL both_strobes: got wr=%0d rd=%0d expected 3/0", wrC, rdC); end
    nCmp++; if (cpuRdata !== 32'h12345678) begin nErr++; $display("FAIL both_data_held: got %h expected 12345678", cpuRdata); end
    nCmp++; if (dC !== 4 || dN !== 1) begin nErr++; $display("FAIL both_done: got cycle %0d count %0d expected 4/1", dC, dN); end
    runCpu(1'b1, 1'b0, 32'h80, 32'h0, rdC, wrC, stC, dC, dN);
    nCmp++; if (cpuRdata !== 32'hCAFEF00D) begin nErr++; $display("FAIL both_readback: got %h expected cafef00d", cpuRdata); end
  endtask

  task automatic test_starvation;
    logic [9:0] order;   // bit i = 1 when the i-th completion was the loader's
    int nDone, both;
    order = '0; nDone = 0; both = 0;
    cpuAddr = 32'h100; cpuRd = 1'b1; cpuWr = 1'b0;
    ldAddr = 32'h40; ldWr = 1'b0; ldReq = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (cpuDone && ldDone) both++;
      if ((cpuDone || ldDone) && nDone < 10) begin
        order[nDone] = ldDone;
        nDone++;
        if (nDone == 10) begin ldReq = 1'b0; cpuRd = 1'b0; end
      end
      @(posedge clk); #1;
    end
    ldReq = 1'b0; cpuRd = 1'b0;
    nCmp++; if (nDone !== 10) begin nErr++; $display("FAIL starve_done_count: got %0d expected 10", nDone); end
    nCmp++; if (order !== 10'b1000010000) begin nErr++; $display("FAIL starve_order: got %b expected 1000010000 (bit0 first)", order); end
    nCmp++; if (both !== 0) begin nErr++; $display("FAIL starve_dual_done: got %0d expected 0", both); end
    nCmp++; if (ldRdata !== 32'h12345678 || cpuRdata !== 32'hDEADBEEF) begin nErr++; $display("FAIL starve_read_data: got ld=%h cpu=%h expected 12345678/deadbeef", ldRdata, cpuRdata); end
  endtask

  task automatic test_back_to_back;
    int doneAt[3];
    int nDone, rdC, stC;
    nDone = 0; rdC = 0; stC = 0;
    doneAt[0] = -1; doneAt[1] = -1; doneAt[2] = -1;
    cpuAddrB = 32'h24; cpuRdB = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (memRdB) rdC++;
      if (cpuStallB) stC++;
      if (cpuDoneB) begin
        if (nDone < 3) doneAt[nDone] = c;
        nDone++;
      end
      @(posedge clk); #1;
      if (nDone >= 3) cpuRdB = 1'b0;
    end
    cpuRdB = 1'b0;
    nCmp++; if (doneAt[0] !== 2) begin nErr++; $display("FAIL w0_first_done: got %0d expected 2", doneAt[0]); end
    nCmp++; if (doneAt[1] !== 5 || doneAt[2] !== 8 || nDone !== 3) begin nErr++; $display("FAIL w0_spacing: got %0d %0d n=%0d expected 5 8 n=3", doneAt[1], doneAt[2], nDone); end
    nCmp++; if (rdC !== 3 || stC !== 6) begin nErr++; $display("FAIL w0_strobes: got rd=%0d stall=%0d expected 3/6", rdC, stC); end
    nCmp++; if (cpuRdataB !== 32'h5A5A0024) begin nErr++; $display("FAIL w0_data: got %h expected 5a5a0024", cpuRdataB); end
  endtask

  task automatic test_reset_mid_write;
    int rdC, wrC, stC, dC, dN, doneSeen;
    doneSeen = 0;
    cpuAddr = 32'h90; cpuWdata = 32'h0BADF00D; cpuWr = 1'b1; cpuRd = 1'b0;
    @(posedge clk); #1;
    nCmp++; if (memWr !== 1'b1) begin nErr++; $display("FAIL rst_write_started: got %b expected 1", memWr); end
    @(posedge clk); #2;
    rstN = 1'b0; #1;
    nCmp++; if (memWr !== 1'b0) begin nErr++; $display("FAIL rst_write_async_drop: got %b expected 0", memWr); end
    nCmp++; if (cpuStall !== 1'b1 || cpuRdata !== 32'h0) begin nErr++; $display("FAIL rst_outputs: got stall=%b data=%h expected 1/0", cpuStall, cpuRdata); end
    cpuWr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (cpuDone) doneSeen++;
    end
    rstN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (cpuDone) doneSeen++;
      @(posedge clk); #1;
    end
    nCmp++; if (doneSeen !== 0) begin nErr++; $display("FAIL rst_no_done: got %0d expected 0", doneSeen); end
    runCpu(1'b1, 1'b0, 32'h100, 32'h0, rdC, wrC, stC, dC, dN);
    nCmp++; if (dC !== 4 || rdC !== 3 || cpuRdata !== 32'hDEADBEEF) begin nErr++; $display("FAIL rst_fresh_read: got done %0d rd %0d data %h expected 4/3/deadbeef", dC, rdC, cpuRdata); end
  endtask

  initial begin
    nCmp = 0; nErr = 0;
    rstN = 1'b0;
    cpuRd = 1'b0; cpuWr = 1'b0; cpuAddr = '0; cpuWdata = '0;
    ldReq = 1'b0; ldWr = 1'b0; ldAddr = '0; ldWdata = '0;
    cpuRdB = 1'b0; cpuWrB = 1'b0; cpuAddrB = '0; cpuWdataB = '0;
    ldReqB = 1'b0; ldWrB = 1'b0; ldAddrB = '0; ldWdataB = '0;
    test_reset();
    test_cpu_read();
    test_loader_write();
    test_rd_wr_both();
    test_starvation();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
